decode_rename_stage: RTL and testbench
======================================

DECODE_RENAME_STAGE -- requirements
Module: decode_rename_stage

Interface
REQ-001 Parameter WORD_SIZE, default 32, datapath width.
REQ-002 Parameter ARCH_REGS, default 32, architectural register count; REG_W = clog2(ARCH_REGS).
REQ-003 Parameter ROB_ENTRY_WIDTH, default 4, ROB tag width.
REQ-004 Parameter NUM_BYPASS, default 6, number of bypass channels; index 0 has highest priority.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 in_valid/in_ready  in/out  1/1  decoded-instruction handshake.
REQ-008 in_rs1, in_rs2, in_rd  in  REG_W each  source and destination indices.
REQ-009 in_wb, in_is_store  in  1/1  instruction writes rd; instruction is a store.
REQ-010 rf_s1_data, rf_s2_data  in  WORD_SIZE  register-file read data for in_rs1/in_rs2.
REQ-011 rs1_rob_entry, rs2_rob_entry  out  ROB_ENTRY_WIDTH  rename tags sent to the ROB for lookup.
REQ-012 rob_s1_data, rob_s2_data / rob_s1_valid, rob_s2_valid  in  WORD_SIZE / 1  ROB lookup result.
REQ-013 byp_data / byp_rob_id / byp_valid  in  NUM_BYPASS*WORD_SIZE / NUM_BYPASS*ROB_ENTRY_WIDTH / NUM_BYPASS  packed bypass channels.
REQ-014 rob_full, rob_assigned_id  in  1 / ROB_ENTRY_WIDTH; rob_alloc  out  1  ROB allocation request.
REQ-015 commit, commit_rd, commit_rob_id, commit_data  in  1/REG_W/ROB_ENTRY_WIDTH/WORD_SIZE  retirement port.
REQ-016 flush  in  1  kill in-flight decode (taken jump or mispredict).
REQ-017 out_valid/out_ready  out/in  1/1; out_s1_data, out_s2_data, out_rob_id, out_rd, out_is_store  registered outputs.

Function
REQ-018 Operand resolution priority per source: index 0 -> zero; rename entry invalid -> rf data; commit with commit_rob_id equal to tag -> commit_data; lowest-index byp_valid channel with matching tag -> byp_data; rob_sN_valid -> rob data; otherwise operand not ready.
REQ-019 Accept = in_valid && both operands ready && !(in_wb && rob_full) && (!out_valid || out_ready) && !flush; in_ready equals accept without the in_valid term.
REQ-020 rob_alloc SHALL equal accept && in_wb && !in_is_store.
REQ-021 On accept with rob_alloc and in_rd != 0, rename entry in_rd SHALL be set valid with tag rob_assigned_id at the next edge.
REQ-022 On commit, entry commit_rd SHALL be invalidated only if its tag equals commit_rob_id; a same-cycle rename of the same rd SHALL win.
REQ-023 Output register: loaded on accept (latency 1 cycle); held unchanged while out_valid && !out_ready; out_valid cleared when out_ready and no accept.
REQ-024 flush SHALL clear out_valid at the next edge and block accept that cycle.
REQ-025 Register 0 SHALL never be renamed; rename table with all ROB tags in use has no special case (ROB enforces via rob_full).

Reset
REQ-026 While rst low: all rename valid bits 0, out_valid 0, all out_* data 0; in_ready and rob_alloc follow combinational rules from reset state.

Configuration
REQ-027 Macro DECODE_RENAME_FLUSH_EN defined: flush additionally clears all rename valid bits at the next edge, overriding same-cycle rename and commit.
REQ-028 Macro undefined: flush affects only out_valid and accept; rename table retains contents.

Structure
REQ-029 Package decode_pkg SHALL hold the operand-source enum (ZERO, RF, COMMIT, BYPASS, ROB, NONE) and default parameter constants.
REQ-030 Sub-module rename_table SHALL hold the valid/tag array with two read ports, one rename write port, one commit port and flush.

Verification
REQ-031 Reset, in_rs1=3, in_rs2=0, rf_s1_data=0x11 -> accept, out_s1_data=0x11, out_s2_data=0 one cycle later.
REQ-032 Rename r5 to tag 2; next instruction reads r5, byp_valid[4] tag 2 data 0xAA and byp_valid[1] tag 2 data 0xBB -> out_s1_data=0xBB.
REQ-033 r5 tagged 2, no bypass, rob_s1_valid=0 -> in_ready=0 for 3 cycles; raise rob_s1_valid data 0x7 -> accept, out_s1_data=0x7.
REQ-034 Commit r5 tag 2 same cycle as rename r5 to tag 6 -> entry r5 remains valid, tag 6.
REQ-035 out_valid=1, out_ready=0 for 4 cycles -> outputs stable, in_ready=0; then flush -> out_valid=0 next cycle.
REQ-036 With DECODE_RENAME_FLUSH_EN: rename r1,r2, flush -> subsequent reads of r1,r2 take rf data; without macro they still resolve via tags.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared operand-source encoding and default sizing for the decode/rename slice
package decode_pkg;
    // Where a source operand's value comes from, in resolution priority order
    typedef enum logic [2:0] {ZERO, RF, COMMIT, BYPASS, ROB, NONE} src_t;
    localparam int DEF_WORD_SIZE       = 32;
    localparam int DEF_ARCH_REGS       = 32;
    localparam int DEF_ROB_ENTRY_WIDTH = 4;
    localparam int DEF_NUM_BYPASS      = 6;
endpackage

// File: rtl/rename_table.sv
// rename_table: architectural register -> ROB tag map with valid bits
//   rd_idx1/rd_idx2 -> rd_valid*/rd_tag*  : two combinational read ports
//   wr_en/wr_idx/wr_tag                   : rename write (wins over a same-cycle commit)
//   commit_en/commit_idx/commit_tag       : retire, clears entry only if tag still matches
//   flush                                 : clears every valid bit, overriding rename and commit
//   rst                                   : asynchronous, active low
module rename_table import decode_pkg::*; #(
    parameter int ARCH_REGS = DEF_ARCH_REGS,
    parameter int TAG_W     = DEF_ROB_ENTRY_WIDTH,
    localparam int REG_W    = $clog2(ARCH_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rd_idx1,
    input  logic [REG_W-1:0] rd_idx2,
    output logic             rd_valid1,
    output logic             rd_valid2,
    output logic [TAG_W-1:0] rd_tag1,
    output logic [TAG_W-1:0] rd_tag2,
    input  logic             wr_en,
    input  logic [REG_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             commit_en,
    input  logic [REG_W-1:0] commit_idx,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic             flush
);
    logic [ARCH_REGS-1:0] valid;
    logic [TAG_W-1:0]     tag [ARCH_REGS];

    assign rd_valid1 = valid[rd_idx1];
    assign rd_valid2 = valid[rd_idx2];
    assign rd_tag1   = tag[rd_idx1];
    assign rd_tag2   = tag[rd_idx2];

    // Entry 0 is never written, so x0 always reads as not renamed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            for (int i = 0; i < ARCH_REGS; i++) tag[i] <= '0;
        end else begin
            for (int i = 1; i < ARCH_REGS; i++) begin
                if (flush) valid[i] <= 1'b0;
                else if (wr_en && wr_idx == REG_W'(i)) begin
                    valid[i] <= 1'b1;
                    tag[i]   <= wr_tag;
                end else if (commit_en && commit_idx == REG_W'(i) && tag[i] == commit_tag) valid[i] <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/decode_rename_stage.sv
// decode_rename_stage: resolves source operands, renames rd to a ROB tag, registers the result
//   in_valid/in_ready, in_rs1/in_rs2/in_rd, in_wb, in_is_store : decoded instruction
//   rf_s*_data, rob_s*_data/valid, byp_*, commit*              : operand sources
//   rs*_rob_entry                                              : tags sent to the ROB for lookup
//   rob_full/rob_assigned_id/rob_alloc                         : ROB allocation
//   flush                                                      : kills in-flight decode
//   out_valid/out_ready, out_*                                 : registered result
//   rst                                                        : asynchronous, active low
// Define DECODE_RENAME_FLUSH_EN to also wipe the rename table on flush.
module decode_rename_stage import decode_pkg::*; #(
    parameter int WORD_SIZE       = DEF_WORD_SIZE,
    parameter int ARCH_REGS       = DEF_ARCH_REGS,
    parameter int ROB_ENTRY_WIDTH = DEF_ROB_ENTRY_WIDTH,
    parameter int NUM_BYPASS      = DEF_NUM_BYPASS,
    localparam int REG_W          = $clog2(ARCH_REGS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [REG_W-1:0]                      in_rs1,
    input  logic [REG_W-1:0]                      in_rs2,
    input  logic [REG_W-1:0]                      in_rd,
    input  logic                                  in_wb,
    input  logic                                  in_is_store,
    input  logic [WORD_SIZE-1:0]                  rf_s1_data,
    input  logic [WORD_SIZE-1:0]                  rf_s2_data,
    output logic [ROB_ENTRY_WIDTH-1:0]            rs1_rob_entry,
    output logic [ROB_ENTRY_WIDTH-1:0]            rs2_rob_entry,
    input  logic [WORD_SIZE-1:0]                  rob_s1_data,
    input  logic [WORD_SIZE-1:0]                  rob_s2_data,
    input  logic                                  rob_s1_valid,
    input  logic                                  rob_s2_valid,
    input  logic [NUM_BYPASS*WORD_SIZE-1:0]       byp_data,
    input  logic [NUM_BYPASS*ROB_ENTRY_WIDTH-1:0] byp_rob_id,
    input  logic [NUM_BYPASS-1:0]                 byp_valid,
    input  logic                                  rob_full,
    input  logic [ROB_ENTRY_WIDTH-1:0]            rob_assigned_id,
    output logic                                  rob_alloc,
    input  logic                                  commit,
    input  logic [REG_W-1:0]                      commit_rd,
    input  logic [ROB_ENTRY_WIDTH-1:0]            commit_rob_id,
    input  logic [WORD_SIZE-1:0]                  commit_data,
    input  logic                                  flush,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WORD_SIZE-1:0]                  out_s1_data,
    output logic [WORD_SIZE-1:0]                  out_s2_data,
    output logic [ROB_ENTRY_WIDTH-1:0]            out_rob_id,
    output logic [REG_W-1:0]                      out_rd,
    output logic                                  out_is_store
);
    logic [REG_W-1:0]           rs    [2];
    logic [WORD_SIZE-1:0]       rf_d  [2];
    logic [WORD_SIZE-1:0]       rob_d [2];
    logic [WORD_SIZE-1:0]       opnd  [2];
    logic [ROB_ENTRY_WIDTH-1:0] tag   [2];
    logic                       ren_v [2];
    logic                       rob_v [2];
    logic [1:0]                 rdy;
    src_t                       src   [2];
    logic                       accept;
    logic                       table_clear;

    assign rs[0]    = in_rs1;
    assign rs[1]    = in_rs2;
    assign rf_d[0]  = rf_s1_data;
    assign rf_d[1]  = rf_s2_data;
    assign rob_d[0] = rob_s1_data;
    assign rob_d[1] = rob_s2_data;
    assign rob_v[0] = rob_s1_valid;
    assign rob_v[1] = rob_s2_valid;
    assign rs1_rob_entry = tag[0];
    assign rs2_rob_entry = tag[1];

`ifdef DECODE_RENAME_FLUSH_EN
    assign table_clear = flush;
`else
    assign table_clear = 1'b0;
`endif

    rename_table #(.ARCH_REGS(ARCH_REGS), .TAG_W(ROB_ENTRY_WIDTH)) u_table (
        .clk(clk),
        .rst(rst),
        .rd_idx1(in_rs1),
        .rd_idx2(in_rs2),
        .rd_valid1(ren_v[0]),
        .rd_valid2(ren_v[1]),
        .rd_tag1(tag[0]),
        .rd_tag2(tag[1]),
        .wr_en(rob_alloc && in_rd != '0),
        .wr_idx(in_rd),
        .wr_tag(rob_assigned_id),
        .commit_en(commit),
        .commit_idx(commit_rd),
        .commit_tag(commit_rob_id),
        .flush(table_clear)
    );

    for (genvar g = 0; g < 2; g++) begin : g_src
        logic                 byp_hit;
        logic [WORD_SIZE-1:0] byp_d;
        // Scan high to low so the lowest-index matching channel is the one left standing
        always_comb begin
            byp_hit = 1'b0;
            byp_d   = '0;
            for (int i = NUM_BYPASS - 1; i >= 0; i--)
                if (byp_valid[i] && byp_rob_id[i*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH] == tag[g]) begin
                    byp_hit = 1'b1;
                    byp_d   = byp_data[i*WORD_SIZE +: WORD_SIZE];
                end
        end
        assign src[g] = rs[g] == '0 ? ZERO :
                        !ren_v[g] ? RF :
                        (commit && commit_rob_id == tag[g]) ? COMMIT :
                        byp_hit ? BYPASS :
                        rob_v[g] ? ROB : NONE;
        assign opnd[g] = src[g] == RF ? rf_d[g] :
                         src[g] == COMMIT ? commit_data :
                         src[g] == BYPASS ? byp_d :
                         src[g] == ROB ? rob_d[g] : '0;
        assign rdy[g] = src[g] != NONE;
    end

    assign in_ready  = &rdy && !(in_wb && rob_full) && (!out_valid || out_ready) && !flush;
    assign accept    = in_valid && in_ready;
    assign rob_alloc = accept && in_wb && !in_is_store;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_s1_data  <= '0;
            out_s2_data  <= '0;
            out_rob_id   <= '0;
            out_rd       <= '0;
            out_is_store <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_s1_data  <= opnd[0];
            out_s2_data  <= opnd[1];
            out_rob_id   <= rob_assigned_id;
            out_rd       <= in_rd;
            out_is_store <= in_is_store;
        end else if (flush || out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_decode_rename_stage.sv
// tb_decode_rename_stage: randomized scoreboard bench against a behavioural rename/operand model
module tb_decode_rename_stage;
    localparam int W = 32, AR = 32, RW = 4, NB = 6, RG = 5;

    logic            clk, rst;
    logic            in_valid, in_ready, in_wb, in_is_store;
    logic [RG-1:0]   in_rs1, in_rs2, in_rd, commit_rd, out_rd;
    logic [W-1:0]    rf_s1_data, rf_s2_data, rob_s1_data, rob_s2_data, commit_data, out_s1_data, out_s2_data;
    logic [RW-1:0]   rs1_rob_entry, rs2_rob_entry, rob_assigned_id, commit_rob_id, out_rob_id;
    logic            rob_s1_valid, rob_s2_valid, rob_full, rob_alloc, commit, flush;
    logic            out_valid, out_ready, out_is_store;
    logic [NB*W-1:0] byp_data;
    logic [NB*RW-1:0] byp_rob_id;
    logic [NB-1:0]   byp_valid;

    decode_rename_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_wb(in_wb), .in_is_store(in_is_store),
        .rf_s1_data(rf_s1_data), .rf_s2_data(rf_s2_data),
        .rs1_rob_entry(rs1_rob_entry), .rs2_rob_entry(rs2_rob_entry),
        .rob_s1_data(rob_s1_data), .rob_s2_data(rob_s2_data),
        .rob_s1_valid(rob_s1_valid), .rob_s2_valid(rob_s2_valid),
        .byp_data(byp_data), .byp_rob_id(byp_rob_id), .byp_valid(byp_valid),
        .rob_full(rob_full), .rob_assigned_id(rob_assigned_id), .rob_alloc(rob_alloc),
        .commit(commit), .commit_rd(commit_rd), .commit_rob_id(commit_rob_id), .commit_data(commit_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s1_data(out_s1_data), .out_s2_data(out_s2_data),
        .out_rob_id(out_rob_id), .out_rd(out_rd), .out_is_store(out_is_store)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  s1;
        logic [W-1:0]  s2;
        logic [RW-1:0] id;
        logic [RG-1:0] rd;
        logic          st;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, errors = 0;
    bit          mv [AR];
    logic [RW-1:0] mt [AR];
    bit          mov;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Operand value from the architectural rules: x0, unrenamed, retiring, bypassed, ROB, else not ready
    function automatic void resolve(input int r, input logic [W-1:0] rf, input bit robv,
                                    input logic [W-1:0] robd, output bit rdy, output logic [W-1:0] d);
        rdy = 1'b1;
        d   = '0;
        if (r == 0) return;
        if (!mv[r]) begin d = rf; return; end
        if (commit && commit_rob_id == mt[r]) begin d = commit_data; return; end
        for (int i = 0; i < NB; i++)
            if (byp_valid[i] && byp_rob_id[i*RW +: RW] == mt[r]) begin d = byp_data[i*W +: W]; return; end
        if (robv) begin d = robd; return; end
        rdy = 1'b0;
    endfunction

    task automatic idle();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_wb = 0; in_is_store = 0;
        rf_s1_data = 0; rf_s2_data = 0; rob_s1_data = 0; rob_s2_data = 0; rob_s1_valid = 0; rob_s2_valid = 0;
        byp_data = 0; byp_rob_id = 0; byp_valid = 0; rob_full = 0; rob_assigned_id = 0;
        commit = 0; commit_rd = 0; commit_rob_id = 0; commit_data = 0; flush = 0; out_ready = 0;
    endtask

    // Inputs are already driven; predict, compare, update the model, advance one clock
    task automatic cycle();
        bit r1, r2, ok, acc;
        logic [W-1:0] d1, d2;
        exp_t e;
        #1;
        resolve(int'(in_rs1), rf_s1_data, rob_s1_valid, rob_s1_data, r1, d1);
        resolve(int'(in_rs2), rf_s2_data, rob_s2_valid, rob_s2_data, r2, d2);
        ok  = r1 && r2 && !(in_wb && rob_full) && (!mov || out_ready) && !flush;
        acc = in_valid && ok;
        chk("in_ready", 64'(in_ready), 64'(ok));
        chk("rob_alloc", 64'(rob_alloc), 64'(acc && in_wb && !in_is_store));
        if (in_rs1 != 0 && mv[in_rs1]) chk("rs1_tag", 64'(rs1_rob_entry), 64'(mt[in_rs1]));
        if (in_rs2 != 0 && mv[in_rs2]) chk("rs2_tag", 64'(rs2_rob_entry), 64'(mt[in_rs2]));
        if (flush && mov && !out_ready && q.size() > 0) q.delete(0);
        if (acc) begin
            e.s1 = d1; e.s2 = d2; e.id = rob_assigned_id; e.rd = in_rd; e.st = in_is_store;
            q.push_back(e);
        end
`ifdef DECODE_RENAME_FLUSH_EN
        if (flush) foreach (mv[i]) mv[i] = 1'b0;
        else
`endif
        begin
            if (commit && mt[commit_rd] == commit_rob_id) mv[commit_rd] = 1'b0;
            if (acc && in_wb && !in_is_store && in_rd != 0) begin
                mv[in_rd] = 1'b1;
                mt[in_rd] = rob_assigned_id;
            end
        end
        mov = acc ? 1'b1 : (flush || out_ready) ? 1'b0 : mov;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected actual=valid required=no pending result");
                end else begin
                    e = q.pop_front();
                    chk("out_s1", 64'(out_s1_data), 64'(e.s1));
                    chk("out_s2", 64'(out_s2_data), 64'(e.s2));
                    chk("out_rob_id", 64'(out_rob_id), 64'(e.id));
                    chk("out_rd", 64'(out_rd), 64'(e.rd));
                    chk("out_is_store", 64'(out_is_store), 64'(e.st));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin : stim
        foreach (mv[i]) begin mv[i] = 1'b0; mt[i] = '0; end
        mov = 1'b0;
        idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_s1", 64'(out_s1_data), 0);
        chk("rst_out_s2", 64'(out_s2_data), 0);
        chk("rst_out_rob_id", 64'(out_rob_id), 0);
        chk("rst_out_rd", 64'(out_rd), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_rob_alloc", 64'(rob_alloc), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // rf read with x0 as second source
        idle(); out_ready = 1; in_valid = 1; in_rs1 = 3; rf_s1_data = 'h11;
        cycle();
        chk("first_s1", 64'(out_s1_data), 'h11);
        chk("first_s2", 64'(out_s2_data), 0);

        // rename r5 -> 2, then read it with two bypass hits; the lower channel wins
        idle(); out_ready = 1; in_valid = 1; in_wb = 1; in_rd = 5; rob_assigned_id = 2;
        cycle();
        idle(); out_ready = 1; in_valid = 1; in_rs1 = 5;
        byp_valid[4] = 1; byp_rob_id[4*RW +: RW] = 2; byp_data[4*W +: W] = 'hAA;
        byp_valid[1] = 1; byp_rob_id[1*RW +: RW] = 2; byp_data[1*W +: W] = 'hBB;
        cycle();
        chk("bypass_prio", 64'(out_s1_data), 'hBB);

        // no source for r5 stalls, then the ROB answers
        idle(); out_ready = 1; in_valid = 1; in_rs1 = 5;
        repeat (3) cycle();
        rob_s1_valid = 1; rob_s1_data = 'h7;
        cycle();
        chk("rob_data", 64'(out_s1_data), 'h7);

        // same-cycle commit of old tag and rename to new tag
        idle(); out_ready = 1; in_valid = 1; in_wb = 1; in_rd = 5; rob_assigned_id = 6;
        commit = 1; commit_rd = 5; commit_rob_id = 2;
        cycle();
        idle(); out_ready = 1; in_rs1 = 5;
        #1;
        chk("rename_wins_tag", 64'(rs1_rob_entry), 6);
        chk("rename_wins_busy", 64'(in_ready), 0);
        cycle();

        // backpressure hold, then flush drops the held result
        idle(); in_valid = 1; in_rs1 = 2; rf_s1_data = 'h55; rob_assigned_id = 9;
        cycle();
        repeat (4) begin
            cycle();
            chk("hold_valid", 64'(out_valid), 1);
            chk("hold_s1", 64'(out_s1_data), 'h55);
            chk("hold_rob_id", 64'(out_rob_id), 9);
        end
        flush = 1;
        cycle();
        chk("flush_clears", 64'(out_valid), 0);

        // rename r1, r2 then flush; reads resolve by rf only when the table is wiped
        idle(); out_ready = 1; in_valid = 1; in_wb = 1; in_rd = 1; rob_assigned_id = 3;
        cycle();
        in_rd = 2; rob_assigned_id = 4;
        cycle();
        idle(); out_ready = 1; flush = 1;
        cycle();
        idle(); out_ready = 1; in_valid = 1; in_rs1 = 1; in_rs2 = 2;
        rf_s1_data = 'h101; rf_s2_data = 'h202;
        rob_s1_valid = 1; rob_s1_data = 'h301; rob_s2_valid = 1; rob_s2_data = 'h302;
        cycle();
`ifdef DECODE_RENAME_FLUSH_EN
        chk("flush_table_s1", 64'(out_s1_data), 'h101);
        chk("flush_table_s2", 64'(out_s2_data), 'h202);
`else
        chk("flush_table_s1", 64'(out_s1_data), 'h301);
        chk("flush_table_s2", 64'(out_s2_data), 'h302);
`endif

        repeat (1500) begin
            idle();
            in_valid = ($urandom % 4) != 0;
            in_rs1 = RG'($urandom % 8);
            in_rs2 = RG'($urandom % 8);
            in_rd = RG'($urandom % 8);
            in_wb = ($urandom % 4) != 0;
            in_is_store = ($urandom % 5) == 0;
            rf_s1_data = $urandom; rf_s2_data = $urandom;
            rob_s1_valid = $urandom % 2; rob_s1_data = $urandom;
            rob_s2_valid = $urandom % 2; rob_s2_data = $urandom;
            for (int i = 0; i < NB; i++) begin
                byp_valid[i] = ($urandom % 4) == 0;
                byp_rob_id[i*RW +: RW] = RW'($urandom % 8);
                byp_data[i*W +: W] = $urandom;
            end
            rob_full = ($urandom % 7) == 0;
            rob_assigned_id = RW'($urandom % 8);
            commit = ($urandom % 3) == 0;
            commit_rd = RG'($urandom % 8);
            commit_rob_id = ($urandom % 2) != 0 ? mt[commit_rd] : RW'($urandom % 8);
            commit_data = $urandom;
            flush = ($urandom % 20) == 0;
            out_ready = ($urandom % 4) != 0;
            cycle();
        end

        idle(); out_ready = 1;
        repeat (3) cycle();
        chk("drain", 64'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
